// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl
// Producer-side hazard control for a 4-stage RISC pipeline (IF, DOF, EX, WB).
// Keeps a copy of the EX-stage destination (DA/RW/LD) and compares it with the
// DOF-stage source addresses. It drives:
//   - the HA/HB Bus_D' forwarding selects,
//   - stall, bubble and flush,
//   - a saturating counter of stall cycles.
// WB is never a hazard because the register file is write-first.
// Build option: define HAZARD_FWD_EN to enable forwarding (then only load-use
// stalls). Without it, every EX RAW stalls for one cycle and HA/HB stay 0.
module hazard_fwd_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_dof,
   input  logic [REG_AW-1:0] AA,
   input  logic [REG_AW-1:0] BA,
   input  logic              MA,
   input  logic              MB,
   input  logic [REG_AW-1:0] DA,
   input  logic              RW,
   input  logic              LD,
   input  logic              br_taken,
   output logic              HA,
   output logic              HB,
   output logic              stall,
   output logic              bubble,
   output logic              flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              state_reg;
   logic [REG_AW-1:0]   da_ex_reg;
   logic                rw_ex_reg;
   logic                ld_ex_reg;
   logic [CNT_W-1:0]    stall_cnt_reg;

   logic                valid_eff;
   logic                br_eff;
   logic                m_a;
   logic                m_b;
   logic                load_use;
   logic                stall_int;
   logic                bubble_int;

   // The DOF instruction only counts when it is live.
   // It is dead while reset is asserted, and dead after a taken branch
   // (the FLUSH cycle).
   assign valid_eff = valid_dof & ~reset & (state_reg != ST_FLUSH);
   assign br_eff    = br_taken & ~reset;

   // RAW match against the instruction in EX. R0 is constant zero, so it never
   // matches. A source that is muxed from PC_1 or IM reads no register.
   assign m_a = valid_eff & ~MA & rw_ex_reg & (da_ex_reg == AA) & (AA != '0);
   assign m_b = valid_eff & ~MB & rw_ex_reg & (da_ex_reg == BA) & (BA != '0);

`ifdef HAZARD_FWD_EN
   // ALU results are forwarded from Bus_D'.
   // A load result only exists in WB, so a load-use match must stall instead.
   assign HA       = m_a & ~ld_ex_reg;
   assign HB       = m_b & ~ld_ex_reg;
   assign load_use = (m_a | m_b) & ld_ex_reg;
`else
   // No forwarding path. Every EX RAW waits one cycle, and the value is then
   // read through the write-first register file.
   logic ld_ex_unused;
   assign ld_ex_unused = ld_ex_reg;
   assign HA           = 1'b0;
   assign HB           = 1'b0;
   assign load_use     = m_a | m_b;
`endif

   // A taken branch wins over a stall.
   // The stalled instruction is on the wrong path anyway.
   assign stall_int  = load_use & ~br_eff;
   assign bubble_int = stall_int | br_eff;

   assign stall     = stall_int;
   assign bubble    = bubble_int;
   assign flush     = br_eff;
   assign stall_cnt = stall_cnt_reg;

   // EX-stage destination copy and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         da_ex_reg     <= '0;
         rw_ex_reg     <= 1'b0;
         ld_ex_reg     <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         da_ex_reg <= DA;
         if (bubble_int) begin
            rw_ex_reg <= 1'b0;
            ld_ex_reg <= 1'b0;
         end else begin
            rw_ex_reg <= RW & valid_eff;
            ld_ex_reg <= LD & valid_eff;
         end
         if (stall_int && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Pipeline control state.
   // STALL and FLUSH each last exactly one cycle, because the bubble they
   // insert into EX clears any match.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_RUN;
      end else begin
         case (state_reg)
            ST_RUN: begin
               if (br_eff) begin
                  state_reg <= ST_FLUSH;
               end else if (stall_int) begin
                  state_reg <= ST_STALL;
               end else begin
                  state_reg <= ST_RUN;
               end
            end
            ST_STALL: state_reg <= ST_RUN;
            ST_FLUSH: state_reg <= ST_RUN;
            default:  state_reg <= ST_RUN;
         endcase
      end
   end

   // A stall is never more than one cycle long.
   // A second stall while already in STALL means the bubble did not clear EX.
   a_single_stall: assert property (@(posedge clk) disable iff (reset)
      !((state_reg == ST_STALL) && stall_int));

endmodule
